// File: rtl/norm_shift_pkg.sv
// Shared constants and result type for the normalisation stage and the ln() stage after it.
package norm_shift_pkg;

  localparam int DW       = 48;
  localparam int CW       = 6;
  localparam int ZERO_CNT = 48;

  typedef struct packed {
    logic [DW-1:0] mant;
    logic [CW-1:0] expo;
    logic          zero;
  } norm_res_t;

  // A count above the sample width can only come from a broken detector; report it as an all-zero sample.
  function automatic norm_res_t norm_result(input logic [DW-1:0] shifted, input logic [CW-1:0] cnt);
    norm_res_t r;
    if (cnt > CW'(ZERO_CNT)) begin
      r.mant = '0;
      r.expo = CW'(ZERO_CNT);
      r.zero = 1'b1;
    end else begin
      r.mant = shifted;
      r.expo = cnt;
      r.zero = (cnt == CW'(ZERO_CNT));
    end
    return r;
  endfunction

endpackage

// File: rtl/norm_shift_if.sv
// Sample-in / result-out bundle of the normalisation stage.
interface norm_shift_if;
  import norm_shift_pkg::*;

  // valid/ready: a transfer happens on a clk edge where valid & ready are both 1; a source holding
  // valid keeps its data stable until that edge; ready may depend combinationally on the downstream ready.
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] din;
  logic [CW-1:0] numz;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] mant;
  logic [CW-1:0] expo;
  logic          zero;

  modport slave (
    input  in_valid, din, numz, out_ready,
    output in_ready, out_valid, mant, expo, zero
  );

  modport master (
    output in_valid, din, numz, out_ready,
    input  in_ready, out_valid, mant, expo, zero
  );

endinterface

// File: rtl/norm_barrel_shl.sv
// Combinational logarithmic left shifter: one level per count bit, zero fill, truncated to DW.
module norm_barrel_shl #(
  parameter int DW = 48,
  parameter int CW = 6
) (
  input  logic [DW-1:0] din,
  input  logic [CW-1:0] sh,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] stg [CW+1];

  assign stg[0] = din;

  // Largest step first (32, 16, ... 1); each level shifts by 2**bit when that count bit is set.
  for (genvar i = 0; i < CW; i++) begin : g_lvl
    localparam int BIT = CW - 1 - i;
    assign stg[i+1] = sh[BIT] ? (stg[i] << (2**BIT)) : stg[i];
  end

  assign dout = stg[CW];

endmodule

// File: rtl/norm_shift.sv
// Normalises each uniform sample so its MSB is 1, using the leading-zero detector's registered count.
module norm_shift
  import norm_shift_pkg::*;
(
  input logic        clk,
  input logic        reset,
  norm_shift_if.slave bus
);

  logic [DW-1:0] d0;
  logic          v0;
  logic          fresh;
  logic [CW-1:0] n0;
  logic [CW-1:0] cnt;
  logic          adv0;
  logic          in_ready_w;
  logic          load;
  logic [DW-1:0] shifted;
  norm_res_t     res_d;
  norm_res_t     res_q;
  logic          out_valid_q;

  // The detector count is only valid the cycle after din was sampled; later cycles use the latched copy.
  assign cnt        = fresh ? bus.numz : n0;
  assign adv0       = v0 & (~out_valid_q | bus.out_ready);
  assign in_ready_w = ~v0 | adv0;
  assign load       = bus.in_valid & in_ready_w;

  norm_barrel_shl #(
    .DW (DW),
    .CW (CW)
  ) u_shl (
    .din  (d0),
    .sh   (cnt),
    .dout (shifted)
  );

  assign res_d = norm_result(shifted, cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d0    <= '0;
      v0    <= 1'b0;
      fresh <= 1'b0;
      n0    <= '0;
    end else if (load) begin
      d0    <= bus.din;
      v0    <= 1'b1;
      fresh <= 1'b1;
    end else if (adv0) begin
      v0    <= 1'b0;
      fresh <= 1'b0;
    end else if (v0 & fresh) begin
      n0    <= bus.numz;
      fresh <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (adv0) begin
      res_q       <= res_d;
      out_valid_q <= 1'b1;
    end else if (bus.out_ready & out_valid_q) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.mant      = res_q.mant;
  assign bus.expo      = res_q.expo;
  assign bus.zero      = res_q.zero;

endmodule

// File: doc/norm_shift.md
Name: norm_shift

Overview:
- Normalisation stage directly downstream of the 48-bit leading-zero detector in the Box-Muller datapath.
- Takes each 48-bit uniform sample and the detector's registered zero count, then left-shifts the sample so its MSB is 1.
- Emits the normalised mantissa and the shift count, which serves as the exponent for the ln() range reduction.
- Two-entry valid/ready pipeline with backpressure; captures the detector's count on the only cycle it is valid.

Parameters:
- DW, 48, sample width; must equal the detector input width.
- CW, 6, count width; must hold the value DW.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  din carries a sample this cycle
- in_ready  out  1  stage accepts din this cycle
- din  in  DW  uniform sample; the same wire drives the detector input
- numz  in  CW  detector registered output; during the cycle after din is sampled it equals the leading-zero count of that din (0..48)
- out_valid  out  1  output register holds a result
- out_ready  in  1  consumer accepts the result
- mant  out  DW  normalised mantissa, din << count
- expo  out  CW  shift count (0..48)
- zero  out  1  sample was all-zero

Behaviour:
- Reset values: in_ready=1, out_valid=0, mant=0, expo=0, zero=0. All internal valids and flags clear on reset.
- Stage S0 holds d0[DW], v0, fresh, n0[CW].
  - Load: on an edge with in_valid & in_ready, d0<=din, v0<=1, fresh<=1.
  - Count source: cnt = fresh ? numz : n0.
  - Latch: on an edge with v0 & fresh where S0 does not advance, n0<=numz and fresh<=0. This keeps the count valid after the detector moves on, regardless of later din values.
- Stage S1 (the output register) is loaded with mant<=d0<<cnt, expo<=cnt, zero<=(cnt==DW), out_valid<=1.
- Advance rule: adv0 = v0 & (~out_valid | out_ready). in_ready = ~v0 | adv0.
- If adv0 fires without a new load, v0<=0. If adv0 and a new load fire together, S0 reloads and fresh<=1.
- out_valid clears on an edge with out_ready & out_valid & ~adv0.
- Latency: a sample accepted at edge k appears with out_valid=1 after edge k+1. Throughput is 1 sample/cycle with out_ready held high.
- Stall: any number of cycles with out_ready=0 holds mant/expo/zero stable. At most two samples are held (S0 + S1), and in_ready=0 while both are full.
- Arithmetic:
  - Shift is logical left, zero fill, truncated to DW.
  - cnt > DW cannot occur; if it does, the result is forced to mant=0, expo=DW, zero=1.
  - mant[DW-1]=1 exactly when zero=0.
- Boundaries:
  - din=0 gives expo=48, mant=0, zero=1.
  - din MSB set gives expo=0 and mant=din.
  - din=1 gives expo=47, mant=48'h800000000000.
- Reset asserted mid-stall discards both held samples. The first sample accepted after reset release behaves normally, because the detector is reset in the same domain.
- No combinational path from din or numz to any output. in_ready depends combinationally on out_ready.

Decomposition:
- Shared package holds:
  - constants DW=48, CW=6, ZERO_CNT=48;
  - a result struct {mant, expo, zero} reused by the downstream ln stage.
- One natural sub-module: norm_barrel_shl, a combinational 6-level log shifter (shift by 32/16/8/4/2/1 from the cnt bits) with DW and CW parameters.
- The control logic stays in norm_shift.

Test Plan:
- Streaming: out_ready=1, back-to-back din = 48'h800000000000, 48'h000000000001, 0, 48'h00F000000000.
  - Required outputs on consecutive cycles, each 2 cycles after input: (mant=800000000000, expo=0, zero=0), (800000000000, 47, 0), (0, 48, 1), (F00000000000, 8, 0).
- Backpressure with changing din: accept 48'h000100000000, then hold out_ready=0 for 5 cycles while din changes every cycle.
  - Required: out_valid=1 with mant=800000000000, expo=15, stable for all 5 cycles.
  - in_ready=0 after the second accept.
  - The second sample's result is correct when out_ready rises.
- Latched count: accept 48'h000000FFFFFF (count 24) with S1 full and out_ready=0; change din to all-ones; release after 3 cycles.
  - Required: expo=24, mant=FFFFFF000000, i.e. n0 was used, not the live numz.
- Simultaneous events: with S0 and S1 full, raise out_ready and in_valid in the same cycle.
  - Required: both stages advance, a new sample is accepted, and no sample is lost or duplicated (scoreboard over 1000 random samples with random out_ready).
- Reset mid-stall: with both stages full, pulse reset for 1 cycle.
  - Required: out_valid=0 and mant/expo/zero=0 immediately (asynchronous), in_ready=1.
  - The next sample 48'h000000000003 yields expo=46.
- Random: 10^5 random din, including a sparse-bit distribution, with random stalls.
  - Required: mant == din << clz(din) and expo == clz(din) against a reference model.
  - Required: mant[47]==~zero on every output.
